// File: rtl/fb_pixel_writer.sv
// Pixel stream consumer: clips iterator coordinates, converts them to linear addresses and queues
// framebuffer writes behind a valid/ready port. Optional clip counter enabled by FB_CLIP_STATS_EN.
module fb_pixel_writer #(
    parameter int CORDW = 10,
    parameter int FB_W  = 640,
    parameter int FB_H  = 480,
    parameter int ADDRW = 19,
    parameter int COLRW = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [COLRW-1:0] colour_i,
    input  logic [CORDW-1:0] pix_x_i,
    input  logic [CORDW-1:0] pix_y_i,
    input  logic             pix_drawing_i,
    input  logic             pix_done_i,
    output logic             pix_oe_o,
    output logic [ADDRW-1:0] mem_addr_o,
    output logic [COLRW-1:0] mem_data_o,
    output logic             mem_we_o,
    input  logic             mem_ready_i,
    output logic             busy_o,
    output logic             done_o
`ifdef FB_CLIP_STATS_EN
    ,
    output logic [15:0]      clip_cnt_o
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CORDW:0] FB_W_LIM = (CORDW+1)'(FB_W);
    localparam logic [CORDW:0] FB_H_LIM = (CORDW+1)'(FB_H);
    localparam logic [CW:0]    OE_LIM   = (CW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   done_q, done_d;

    logic [COLRW-1:0] colour_q;
    logic             accept;
    logic             start_ok;

    logic             s1_valid_q;
    logic             s1_inr_q;
    logic [CORDW-1:0] s1_x_q;
    logic [CORDW-1:0] s1_y_q;

    logic             s2_valid_q;
    logic             s2_inr_q;
    logic [ADDRW-1:0] s2_addr_q;

    logic [ADDRW-1:0] fifo_addr_q [DEPTH];
    logic [COLRW-1:0] fifo_data_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             pipe_empty;
    logic [CW:0]      inflight;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (pix_done_i) state_d = DRAIN;
            DRAIN: begin
                if (pipe_empty && fifo_empty) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o   = (state_q != IDLE);
        done_o   = done_q;
        start_ok = (state_q == IDLE) && start_i;
        accept   = (state_q == RUN) && pix_drawing_i;
        // Counting every in-flight slot keeps the FIFO from ever overflowing.
        pix_oe_o = (state_q == RUN) && (inflight <= OE_LIM);
    end

    assign inflight   = {1'b0, count_q} + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q);
    assign pipe_empty = !s1_valid_q && !s2_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colour_q <= '0;
        end else if (start_ok) begin
            colour_q <= colour_i;
        end
    end

    // ---------------- Pipeline ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_inr_q   <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_inr_q   <= 1'b0;
            s2_addr_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_x_q   <= pix_x_i;
                s1_y_q   <= pix_y_i;
                s1_inr_q <= ({1'b0, pix_x_i} < FB_W_LIM) && ({1'b0, pix_y_i} < FB_H_LIM);
            end
            s2_valid_q <= s1_valid_q;
            s2_inr_q   <= s1_valid_q && s1_inr_q;
            s2_addr_q  <= ADDRW'(s1_y_q) * ADDRW'(FB_W) + ADDRW'(s1_x_q);
        end
    end

    // ---------------- First-word-fall-through write FIFO ----------------
    assign fifo_empty = (count_q == '0);
    assign push       = s2_valid_q && s2_inr_q;
    assign pop        = !fifo_empty && mem_ready_i;
    assign count_d    = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= s2_addr_q;
                fifo_data_q[wr_ptr_q] <= colour_q;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign mem_we_o   = !fifo_empty;
    assign mem_addr_o = fifo_addr_q[rd_ptr_q];
    assign mem_data_o = fifo_data_q[rd_ptr_q];

`ifdef FB_CLIP_STATS_EN
    logic [15:0] clip_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt_q <= '0;
        end else if (start_ok) begin
            clip_cnt_q <= '0;
        end else if (s2_valid_q && !s2_inr_q && (clip_cnt_q != 16'hFFFF)) begin
            clip_cnt_q <= clip_cnt_q + 16'd1;
        end
    end

    assign clip_cnt_o = clip_cnt_q;
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: an iterator-like driver honours pix_oe, and a negedge
// monitor logs every write handshake and done pulse for the scenario tasks to compare.
module tb_fb_pixel_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [11:0] colour_i;
    logic [9:0]  pix_x_i;
    logic [9:0]  pix_y_i;
    logic        pix_drawing_i;
    logic        pix_done_i;
    logic        pix_oe_o;
    logic [18:0] mem_addr_o;
    logic [11:0] mem_data_o;
    logic        mem_we_o;
    logic        mem_ready_i;
    logic        busy_o;
    logic        done_o;
`ifdef FB_CLIP_STATS_EN
    logic [15:0] clip_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cnt = 0;
    int first_acc_cyc = 0;

    logic [18:0] log_addr[$];
    logic [11:0] log_data[$];
    int          log_cyc[$];
    logic [9:0]  qx[$];
    logic [9:0]  qy[$];

    fb_pixel_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .colour_i     (colour_i),
        .pix_x_i      (pix_x_i),
        .pix_y_i      (pix_y_i),
        .pix_drawing_i(pix_drawing_i),
        .pix_done_i   (pix_done_i),
        .pix_oe_o     (pix_oe_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_we_o     (mem_we_o),
        .mem_ready_i  (mem_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef FB_CLIP_STATS_EN
        ,
        .clip_cnt_o   (clip_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we_o && mem_ready_i) begin
            log_addr.push_back(mem_addr_o);
            log_data.push_back(mem_data_o);
            log_cyc.push_back(cyc);
            $display("cycle %0d: write addr=%0d data=%03h", cyc, mem_addr_o, mem_data_o);
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            $display("cycle %0d: done pulse", cyc);
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic start_shape(input logic [11:0] c);
        @(posedge clk); #1;
        start_i  = 1'b1;
        colour_i = c;
        @(posedge clk); #1;
        start_i  = 1'b0;
    endtask

    // done_mode: 0 = no pix_done, 1 = pix_done the cycle after the last pixel, 2 = with the last pixel
    task automatic drive_pixels(input int max_cycles, input int done_mode);
        int n = 0;
        while (n < max_cycles && qx.size() > 0) begin
            @(posedge clk); #1;
            n++;
            if (pix_oe_o) begin
                pix_x_i       = qx.pop_front();
                pix_y_i       = qy.pop_front();
                pix_drawing_i = 1'b1;
                if (acc_cnt == 0) first_acc_cyc = cyc + 1;
                acc_cnt++;
                if (done_mode == 2 && qx.size() == 0) pix_done_i = 1'b1;
            end else begin
                pix_drawing_i = 1'b0;
            end
        end
        @(posedge clk); #1;
        pix_drawing_i = 1'b0;
        pix_done_i    = (qx.size() == 0 && done_mode == 1);
        if (pix_done_i) begin
            @(posedge clk); #1;
            pix_done_i = 1'b0;
        end
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (done_cnt == base) begin
            errors++;
            $display("FAIL done_timeout: done_cnt=%0d required=%0d", done_cnt, base + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; colour_i = '0; pix_x_i = '0; pix_y_i = '0;
        pix_drawing_i = 1'b0; pix_done_i = 1'b0; mem_ready_i = 1'b0;
        #1;
        checks++;
        if ({pix_oe_o, mem_we_o, busy_o, done_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: oe/we/busy/done=%b required=0000", {pix_oe_o, mem_we_o, busy_o, done_o});
        end
        checks++;
        if (mem_addr_o !== 19'd0 || mem_data_o !== 12'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%0d data=%03h required 0/000", mem_addr_o, mem_data_o);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [18:0] exp_a[4];
        int base = done_cnt;
        exp_a[0] = 19'd641; exp_a[1] = 19'd642; exp_a[2] = 19'd1281; exp_a[3] = 19'd1282;
        clear_log();
        mem_ready_i = 1'b1;
        start_shape(12'hF0A);
        checks++;
        if (busy_o !== 1'b1 || pix_oe_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_run: busy=%b oe=%b required 1/1", busy_o, pix_oe_o);
        end
        qx = '{10'd1, 10'd2, 10'd1, 10'd2};
        qy = '{10'd1, 10'd1, 10'd2, 10'd2};
        acc_cnt = 0;
        drive_pixels(20, 1);
        wait_done(base);
        checks++;
        if (log_addr.size() != 4) begin
            errors++;
            $display("FAIL basic_count: writes=%0d required=4", log_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_addr[i] !== exp_a[i] || log_data[i] !== 12'hF0A) begin
                    errors++;
                    $display("FAIL basic_write%0d: addr=%0d data=%03h required %0d/F0A", i, log_addr[i], log_data[i], exp_a[i]);
                end
            end
            checks++;
            if (log_cyc[0] != first_acc_cyc + 2) begin
                errors++;
                $display("FAIL basic_latency: first we cycle=%0d required=%0d", log_cyc[0], first_acc_cyc + 2);
            end
            checks++;
            if (done_cyc != log_cyc[3] + 2) begin
                errors++;
                $display("FAIL basic_done_time: done cycle=%0d required=%0d", done_cyc, log_cyc[3] + 2);
            end
        end
        repeat (5) @(posedge clk); #1;
        checks++;
        if (done_cnt != base + 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_once: done_cnt=%0d busy=%b required %0d/0", done_cnt, busy_o, base + 1);
        end
    endtask

    task automatic test_backpressure();
        int base = done_cnt;
        clear_log();
        mem_ready_i = 1'b0;
        start_shape(12'h0AA);
        qx.delete(); qy.delete();
        for (int i = 0; i < 8; i++) begin
            qx.push_back(10'(10 + i));
            qy.push_back(10'd3);
        end
        acc_cnt = 0;
        drive_pixels(10, 0);
        checks++;
        if (acc_cnt != 4 || pix_oe_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: accepted=%0d oe=%b required 4/0", acc_cnt, pix_oe_o);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 19'd1930) begin
            errors++;
            $display("FAIL bp_head: we=%b addr=%0d required 1/1930", mem_we_o, mem_addr_o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (mem_addr_o !== 19'd1930 || log_addr.size() != 0) begin
            errors++;
            $display("FAIL bp_hold: addr=%0d writes=%0d required 1930/0", mem_addr_o, log_addr.size());
        end
        @(posedge clk); #1;
        mem_ready_i = 1'b1;
        drive_pixels(40, 1);
        wait_done(base);
        checks++;
        if (log_addr.size() != 8) begin
            errors++;
            $display("FAIL bp_count: writes=%0d required=8", log_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_addr[i] !== 19'(1930 + i) || log_data[i] !== 12'h0AA) begin
                    errors++;
                    $display("FAIL bp_write%0d: addr=%0d data=%03h required %0d/0AA", i, log_addr[i], log_data[i], 1930 + i);
                end
            end
        end
    endtask

    task automatic test_clipping();
        int base = done_cnt;
        clear_log();
        mem_ready_i = 1'b1;
        start_shape(12'h5C3);
        qx = '{10'd640, 10'd3, 10'd639};
        qy = '{10'd5, 10'd480, 10'd479};
        acc_cnt = 0;
        drive_pixels(20, 1);
        wait_done(base);
        checks++;
        if (log_addr.size() != 1) begin
            errors++;
            $display("FAIL clip_count: writes=%0d required=1", log_addr.size());
        end else begin
            checks++;
            if (log_addr[0] !== 19'd307199 || log_data[0] !== 12'h5C3) begin
                errors++;
                $display("FAIL clip_write: addr=%0d data=%03h required 307199/5C3", log_addr[0], log_data[0]);
            end
        end
`ifdef FB_CLIP_STATS_EN
        checks++;
        if (clip_cnt !== 16'd2) begin
            errors++;
            $display("FAIL clip_cnt: value=%0d required=2", clip_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int base = done_cnt;
        clear_log();
        mem_ready_i = 1'b0;
        start_shape(12'h321);
        qx = '{10'd7, 10'd8, 10'd9};
        qy = '{10'd4, 10'd4, 10'd4};
        acc_cnt = 0;
        drive_pixels(10, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_we_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: we=%b busy=%b required 1/1", mem_we_o, busy_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_we_o, busy_o, pix_oe_o} !== 3'b000) begin
            errors++;
            $display("FAIL rst_async: we/busy/oe=%b required 000", {mem_we_o, busy_o, pix_oe_o});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ready_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (log_addr.size() != 0 || busy_o !== 1'b0 || mem_we_o !== 1'b0 || done_cnt != base) begin
            errors++;
            $display("FAIL rst_after: writes=%0d busy=%b we=%b dones=%0d required 0/0/0/%0d",
                     log_addr.size(), busy_o, mem_we_o, done_cnt, base);
        end
    endtask

    task automatic test_start_guard();
        int base = done_cnt;
        clear_log();
        mem_ready_i = 1'b0;
        start_shape(12'h456);
        qx = '{10'd20, 10'd21};
        qy = '{10'd0, 10'd0};
        acc_cnt = 0;
        drive_pixels(10, 0);
        start_i  = 1'b1;
        colour_i = 12'h123;
        @(posedge clk); #1;
        start_i  = 1'b0;
        mem_ready_i = 1'b1;
        qx = '{10'd22, 10'd23};
        qy = '{10'd0, 10'd0};
        drive_pixels(20, 1);
        wait_done(base);
        checks++;
        if (log_addr.size() != 4) begin
            errors++;
            $display("FAIL guard_count: writes=%0d required=4", log_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_addr[i] !== 19'(20 + i) || log_data[i] !== 12'h456) begin
                    errors++;
                    $display("FAIL guard_write%0d: addr=%0d data=%03h required %0d/456", i, log_addr[i], log_data[i], 20 + i);
                end
            end
        end
        repeat (10) @(posedge clk); #1;
        checks++;
        if (done_cnt != base + 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL guard_done: done_cnt=%0d busy=%b required %0d/0", done_cnt, busy_o, base + 1);
        end
    endtask

    task automatic test_simultaneous();
        int base = done_cnt;
        clear_log();
        mem_ready_i = 1'b1;
        start_shape(12'h777);
        qx = '{10'd5, 10'd6};
        qy = '{10'd0, 10'd0};
        acc_cnt = 0;
        drive_pixels(10, 2);
        wait_done(base);
        checks++;
        if (log_addr.size() != 2) begin
            errors++;
            $display("FAIL simul_count: writes=%0d required=2", log_addr.size());
        end else begin
            checks++;
            if (log_addr[1] !== 19'd6 || log_data[1] !== 12'h777) begin
                errors++;
                $display("FAIL simul_last: addr=%0d data=%03h required 6/777", log_addr[1], log_data[1]);
            end
            checks++;
            if (done_cyc != log_cyc[1] + 2) begin
                errors++;
                $display("FAIL simul_done_time: done cycle=%0d required=%0d", done_cyc, log_cyc[1] + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_clipping();
        test_reset_mid();
        test_start_guard();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
